image_downsample_param: RTL and testbench
=========================================

Name: image_downsample_param

Overview:
- Parametrised 2:1 image decimator reading a source frame from an external single-port BRAM and streaming a half-resolution frame to an external write port.
- Successor to the fixed half-size resizer: generalised in pixel depth, frame size and BRAM read latency.
- Adds a runtime mode: top-left subsampling or 2x2 box averaging.
- Fully pipelined: one read issued per cycle.
- Sits between the source image BRAM and the next pyramid octave or blur stage in the scale-space chain.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- WIDTH, 64, source width in pixels; even, >=2 (elaboration error otherwise).
- HEIGHT, 64, source height in pixels; even, >=2 (elaboration error otherwise).
- READ_LATENCY, 2, cycles from address presented to data valid on ext_pixel_in (2 = HIGH_PERFORMANCE BRAM, 1 = LOW_LATENCY).

Ports:
- clk_in  in  1  single system clock, rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- start_in  in  1  one-cycle start pulse; ignored while busy_out=1.
- mode_in  in  1  0 = subsample, 1 = 2x2 average; sampled only on an accepted start.
- ext_read_addr  out  $clog2(WIDTH*HEIGHT)  source address, raster order (y*WIDTH+x).
- ext_read_addr_valid  out  1  read strobe; drives BRAM enable.
- ext_pixel_in  in  BIT_DEPTH  BRAM read data.
- ext_write_addr  out  $clog2(WIDTH/2*HEIGHT/2)  destination address (oy*WIDTH/2+ox).
- ext_write_valid  out  1  one-cycle write strobe per output pixel.
- ext_pixel_out  out  BIT_DEPTH  output pixel.
- center_x_out  out  $clog2(WIDTH)  source x (2*ox) of the group currently issuing; debug.
- center_y_out  out  $clog2(HEIGHT)  source y (2*oy) of the group currently issuing; debug.
- busy_out  out  1  high while a frame is in progress.
- resize_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert): every output goes to 0. FSM returns to IDLE. Counters, accumulator, valid/tag shift pipeline and latched mode clear. Reset mid-frame abandons the frame; no done pulse.
- FSM states:
  - IDLE -> ISSUE on start_in while idle.
  - ISSUE -> DRAIN after the final read is issued.
  - DRAIN -> DONE when the last write has been emitted.
  - DONE -> IDLE after one cycle.
- busy_out: high from the cycle after the accepted start through the DONE cycle inclusive.
- ISSUE:
  - ext_read_addr_valid is high every cycle, with a new address each cycle; there are no bubbles.
  - Subsample: one read per output, at (2ox, 2oy).
  - Average: four reads per output, in order (2ox,2oy), (2ox+1,2oy), (2ox,2oy+1), (2ox+1,2oy+1).
  - Outputs are issued in raster order, ox fastest.
- Read tracking: each issued read carries a tag (first-of-group, last-of-group) through a READ_LATENCY-deep shift register. Data is captured from ext_pixel_in when the tag emerges.
- Arithmetic:
  - Accumulator is BIT_DEPTH+2 bits, loaded on first-of-group and added to on the others.
  - Average output = sum>>2 (floor, truncation). Subsample output = the captured sample unchanged.
- Write timing:
  - ext_write_valid pulses in cycle k+READ_LATENCY+1, where k is the cycle the group's last read was presented.
  - ext_pixel_out and ext_write_addr are valid only while ext_write_valid=1.
  - ext_write_addr increments by 1 per write, starting at 0.
- Throughput:
  - Subsample: one write per cycle in steady state.
  - Average: one write every 4 cycles.
- Total frame cycles, from the first read cycle to resize_done:
  - Subsample: WIDTH*HEIGHT/4 + READ_LATENCY + 1.
  - Average: WIDTH*HEIGHT + READ_LATENCY + 1.
  - resize_done fires in the cycle immediately after the final ext_write_valid.
- Boundaries:
  - Row wrap: ox returns to 0 and oy increments with no idle cycle.
  - The final group's addresses must not exceed WIDTH*HEIGHT-1.
  - start_in coincident with resize_done is ignored.
  - start_in on the cycle after done begins a new frame.
- center_x_out / center_y_out hold the last issued group's coordinates when idle.

Test Plan:
- WIDTH=HEIGHT=4, mode 0, pixel[i]=i:
  - writes 0,2,8,10 at addresses 0..3.
  - resize_done 4+2+1 = 7 cycles after the first read.
- WIDTH=HEIGHT=4, mode 1, pixel[i]=i:
  - outputs floor((0+1+4+5)/4)=2, then 4, 10, 12.
  - Read address sequence starts 0,1,4,5,2,3,6,7.
  - Average-mode overflow: all pixels 255 -> every output 255 (no wrap).
- Default 64x64 in both modes, using the image.mem BRAM model:
  - 1024 writes; output matches a software reference.
  - ext_read_addr_valid has no gaps.
  - Done occurs at cycle 1027 (mode 0) and 4099 (mode 1).
- READ_LATENCY=1 with a LOW_LATENCY BRAM model, 4x4 mode 0:
  - same data as the first scenario, each write one cycle earlier.
- start_in pulsed during busy and on the done cycle:
  - both ignored; exactly one frame of writes.
  - A start one cycle later runs a full second frame.
- rst_in asserted mid-frame (after 100 writes):
  - all outputs 0 immediately.
  - No further writes and no resize_done.
  - A subsequent start produces a complete, correct frame from address 0.

Source files
------------

// File: rtl/image_downsample_param.sv
// image_downsample_param: 2:1 frame decimator (top-left subsample or 2x2 box average) reading a fixed-latency BRAM
// Ports: clk_in/rst_in (async, active-high); start_in/mode_in launch a frame (mode 0 subsample, 1 average);
// ext_read_* drive the source BRAM and ext_pixel_in returns its data READ_LATENCY cycles later;
// ext_write_* stream the half-resolution frame; center_*_out show the issuing group; busy_out/resize_done report progress.
module image_downsample_param #(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int HEIGHT = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic                                 mode_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]      ext_read_addr,
  output logic                                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                 ext_pixel_in,
  output logic [$clog2(WIDTH/2*HEIGHT/2)-1:0]  ext_write_addr,
  output logic                                 ext_write_valid,
  output logic [BIT_DEPTH-1:0]                 ext_pixel_out,
  output logic [$clog2(WIDTH)-1:0]             center_x_out,
  output logic [$clog2(HEIGHT)-1:0]            center_y_out,
  output logic                                 busy_out,
  output logic                                 resize_done
);
  localparam int AW = $clog2(WIDTH*HEIGHT);
  localparam int OW = $clog2(WIDTH/2*HEIGHT/2);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int ACC_W = BIT_DEPTH + 2;
  localparam int NOUT = WIDTH*HEIGHT/4;
  if (WIDTH < 2 || WIDTH % 2 != 0 || HEIGHT < 2 || HEIGHT % 2 != 0) begin : g_bad_size
    $error("image_downsample_param: WIDTH and HEIGHT must be even and >= 2");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("image_downsample_param: READ_LATENCY must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [1:0] sub_q, sub_d;
  logic [READ_LATENCY-1:0] tv_q, tv_d, tf_q, tf_d, tl_q, tl_d;
  logic [READ_LATENCY:0] tv_n, tf_n, tl_n;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic wv_q, wv_d;
  logic [BIT_DEPTH-1:0] pout_q, pout_d;
  logic [OW-1:0] waddr_q, waddr_d;
  logic issue, grp_end, x_last, y_last, frame_end, cap;
  logic [XW-1:0] src_x;
  logic [YW-1:0] src_y;
  assign issue = state_q == ISSUE;
  // in subsample mode every read is a whole group; sub_q only walks the 2x2 quad when averaging
  assign grp_end = !mode_q || sub_q == 2'd3;
  assign x_last = ox_q == XW'(WIDTH/2 - 1);
  assign y_last = oy_q == YW'(HEIGHT/2 - 1);
  assign frame_end = grp_end && x_last && y_last;
  assign src_x = (ox_q << 1) | XW'(sub_q[0]);
  assign src_y = (oy_q << 1) | YW'(sub_q[1]);
  assign cap = tv_q[READ_LATENCY-1];
  assign sum = tf_q[READ_LATENCY-1] ? ACC_W'(ext_pixel_in) : acc_q + ACC_W'(ext_pixel_in);
  assign ext_read_addr = issue ? AW'(src_y) * AW'(WIDTH) + AW'(src_x) : '0;
  assign ext_read_addr_valid = issue;
  assign ext_write_addr = waddr_q;
  assign ext_write_valid = wv_q;
  assign ext_pixel_out = pout_q;
  assign center_x_out = ox_q << 1;
  assign center_y_out = oy_q << 1;
  assign busy_out = state_q != IDLE;
  assign resize_done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    ox_d = ox_q;
    oy_d = oy_q;
    sub_d = sub_q;
    waddr_d = waddr_q + OW'(wv_q);
    // tag pipeline: bit 0 is the read issued this cycle, the top bit lines up with its returning data
    tv_n = {tv_q, issue};
    tf_n = {tf_q, !mode_q || sub_q == 2'd0};
    tl_n = {tl_q, grp_end};
    tv_d = tv_n[READ_LATENCY-1:0];
    tf_d = tf_n[READ_LATENCY-1:0];
    tl_d = tl_n[READ_LATENCY-1:0];
    acc_d = cap ? sum : acc_q;
    wv_d = cap && tl_q[READ_LATENCY-1];
    pout_d = mode_q ? BIT_DEPTH'(sum >> 2) : ext_pixel_in;
    if (state_q == IDLE && start_in) begin
      state_d = ISSUE;
      mode_d = mode_in;
      ox_d = '0;
      oy_d = '0;
      sub_d = '0;
      waddr_d = '0;
    end
    if (issue) begin
      sub_d = mode_q ? sub_q + 2'd1 : 2'd0;
      // counters freeze on the final group so the center outputs keep its coordinates while idle
      if (frame_end) state_d = DRAIN;
      else if (grp_end) begin
        ox_d = x_last ? '0 : ox_q + 1'b1;
        oy_d = x_last ? oy_q + 1'b1 : oy_q;
      end
    end
    if (state_q == DRAIN && wv_q && waddr_q == OW'(NOUT - 1)) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      ox_q <= '0;
      oy_q <= '0;
      sub_q <= '0;
      tv_q <= '0;
      tf_q <= '0;
      tl_q <= '0;
      acc_q <= '0;
      wv_q <= 1'b0;
      pout_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      sub_q <= sub_d;
      tv_q <= tv_d;
      tf_q <= tf_d;
      tl_q <= tl_d;
      acc_q <= acc_d;
      wv_q <= wv_d;
      pout_q <= pout_d;
      waddr_q <= waddr_d;
    end
  end
endmodule

// File: tb/tb_image_downsample_param.sv
// tb_image_downsample_param: model-checked bench for 64x64/RL2, 4x4/RL2 and 4x4/RL1 instances
module tb_image_downsample_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic start [3];
  logic mode [3];
  logic [7:0] b1 [3];
  logic [7:0] b2 [3];
  logic [11:0] ra0;
  logic [3:0] ra1, ra2;
  logic [9:0] wa0;
  logic [1:0] wa1, wa2;
  logic [5:0] cx0, cy0;
  logic [1:0] cx1, cy1, cx2, cy2;
  logic rv [3];
  logic wv [3];
  logic [7:0] wp [3];
  logic busy [3];
  logic done [3];
  int ra [3];
  int wa [3];
  int cx [3];
  int cy [3];
  assign ra[0] = int'(ra0);
  assign ra[1] = int'(ra1);
  assign ra[2] = int'(ra2);
  assign wa[0] = int'(wa0);
  assign wa[1] = int'(wa1);
  assign wa[2] = int'(wa2);
  assign cx[0] = int'(cx0);
  assign cx[1] = int'(cx1);
  assign cx[2] = int'(cx2);
  assign cy[0] = int'(cy0);
  assign cy[1] = int'(cy1);
  assign cy[2] = int'(cy2);
  image_downsample_param u0 (
    .clk_in(clk), .rst_in(rst[0]), .start_in(start[0]), .mode_in(mode[0]),
    .ext_read_addr(ra0), .ext_read_addr_valid(rv[0]), .ext_pixel_in(b2[0]),
    .ext_write_addr(wa0), .ext_write_valid(wv[0]), .ext_pixel_out(wp[0]),
    .center_x_out(cx0), .center_y_out(cy0), .busy_out(busy[0]), .resize_done(done[0]));
  image_downsample_param #(.WIDTH(4), .HEIGHT(4)) u1 (
    .clk_in(clk), .rst_in(rst[1]), .start_in(start[1]), .mode_in(mode[1]),
    .ext_read_addr(ra1), .ext_read_addr_valid(rv[1]), .ext_pixel_in(b2[1]),
    .ext_write_addr(wa1), .ext_write_valid(wv[1]), .ext_pixel_out(wp[1]),
    .center_x_out(cx1), .center_y_out(cy1), .busy_out(busy[1]), .resize_done(done[1]));
  image_downsample_param #(.WIDTH(4), .HEIGHT(4), .READ_LATENCY(1)) u2 (
    .clk_in(clk), .rst_in(rst[2]), .start_in(start[2]), .mode_in(mode[2]),
    .ext_read_addr(ra2), .ext_read_addr_valid(rv[2]), .ext_pixel_in(b1[2]),
    .ext_write_addr(wa2), .ext_write_valid(wv[2]), .ext_pixel_out(wp[2]),
    .center_x_out(cx2), .center_y_out(cy2), .busy_out(busy[2]), .resize_done(done[2]));
  int pat [3];
  int fmode [3];
  int tcyc [3];
  bit run [3];
  int wcount [3];
  int wlog_v [3][16];
  int wlog_t [3][16];
  int rlog [3][8];
  int done_t [3];
  int checks = 0;
  int errors = 0;
  function automatic int wof(int d);
    return d == 0 ? 64 : 4;
  endfunction
  function automatic int rlof(int d);
    return d == 2 ? 1 : 2;
  endfunction
  function automatic int pixf(int p, int a);
    return p == 0 ? a % 256 : p == 1 ? 255 : (a * 37 + (a / 64) * 11 + 5) % 256;
  endfunction
  function automatic int rd_addr(int w, int m, int r);
    int g;
    int s;
    g = m != 0 ? r / 4 : r;
    s = m != 0 ? r % 4 : 0;
    return 2 * (g / (w / 2)) * w + 2 * (g % (w / 2)) + (s % 2) + (s / 2) * w;
  endfunction
  function automatic int out_pix(int w, int m, int p, int j);
    int b;
    b = 2 * (j / (w / 2)) * w + 2 * (j % (w / 2));
    return m != 0 ? (pixf(p, b) + pixf(p, b + 1) + pixf(p, b + w) + pixf(p, b + w + 1)) / 4 : pixf(p, b);
  endfunction
  function automatic int tot_of(int d, int m);
    return (m != 0 ? wof(d) * wof(d) : wof(d) * wof(d) / 4) + rlof(d) + 1;
  endfunction
  task automatic chk(string nm, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d: got %0d expected %0d", nm, d, tcyc[d], act, exp);
    end
  endtask
  always @(posedge clk)
    for (int d = 0; d < 3; d++) begin
      b1[d] <= 8'(pixf(pat[d], ra[d]));
      b2[d] <= b1[d];
    end
  int ct, cw, crl, cm, cnr, cper, cu, ctot, cnout, cg, cj;
  bit cwe;
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      if (!run[d]) begin
        chk("idle_rd_valid", d, rv[d], 0);
        chk("idle_wr_valid", d, wv[d], 0);
        chk("idle_done", d, done[d], 0);
        chk("idle_busy", d, busy[d], 0);
      end else begin
        ct = tcyc[d];
        cw = wof(d);
        crl = rlof(d);
        cm = fmode[d];
        cnr = cm != 0 ? cw * cw : cw * cw / 4;
        cnout = cw * cw / 4;
        cper = cm != 0 ? 4 : 1;
        ctot = cnr + crl + 1;
        chk("rd_valid", d, rv[d], ct < cnr ? 1 : 0);
        if (ct < cnr) begin
          cg = cm != 0 ? ct / 4 : ct;
          chk("rd_addr", d, ra[d], rd_addr(cw, cm, ct));
          chk("center_x", d, cx[d], 2 * (cg % (cw / 2)));
          chk("center_y", d, cy[d], 2 * (cg / (cw / 2)));
          if (ct < 8) rlog[d][ct] = ra[d];
        end
        cu = ct - crl - 1 - (cper - 1);
        cwe = cu >= 0 && cu % cper == 0 && cu / cper < cnout;
        chk("wr_valid", d, wv[d], cwe ? 1 : 0);
        if (cwe) begin
          cj = cu / cper;
          chk("wr_addr", d, wa[d], cj);
          chk("wr_pixel", d, wp[d], out_pix(cw, cm, pat[d], cj));
        end
        if (wv[d]) begin
          if (wcount[d] < 16) begin
            wlog_v[d][wcount[d]] = wp[d];
            wlog_t[d][wcount[d]] = ct;
          end
          wcount[d]++;
        end
        chk("done", d, done[d], ct == ctot ? 1 : 0);
        if (done[d]) done_t[d] = ct;
        chk("busy", d, busy[d], ct <= ctot ? 1 : 0);
        tcyc[d]++;
      end
    end
  task automatic go(int d, int m, int p);
    pat[d] = p;
    mode[d] = m != 0;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    mode[d] = m == 0;
    fmode[d] = m;
    tcyc[d] = 0;
    wcount[d] = 0;
    done_t[d] = -1;
    run[d] = 1'b1;
  endtask
  task automatic run_frame(int d, int m, int p);
    go(d, m, p);
    repeat (tot_of(d, m) + 3) @(posedge clk);
    #1;
    run[d] = 1'b0;
  endtask
  task automatic chk_zero(string nm, int d);
    chk({nm, "_rd_valid"}, d, rv[d], 0);
    chk({nm, "_rd_addr"}, d, ra[d], 0);
    chk({nm, "_wr_valid"}, d, wv[d], 0);
    chk({nm, "_wr_addr"}, d, wa[d], 0);
    chk({nm, "_wr_pixel"}, d, wp[d], 0);
    chk({nm, "_center"}, d, cx[d] + cy[d], 0);
    chk({nm, "_busy"}, d, busy[d], 0);
    chk({nm, "_done"}, d, done[d], 0);
  endtask
  task automatic chk_four(string nm, int d, int e0, int e1, int e2, int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, d, wcount[d], 4);
    for (int i = 0; i < 4; i++) chk(nm, d, wlog_v[d][i], e[i]);
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      mode[d] = 1'b0;
      pat[d] = 0;
      fmode[d] = 0;
      tcyc[d] = 0;
      run[d] = 1'b0;
      wcount[d] = 0;
      done_t[d] = -1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_zero("reset", d);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_frame(1, 0, 0);
    chk_four("sub4_pix", 1, 0, 2, 8, 10);
    chk("sub4_first_wr_t", 1, wlog_t[1][0], 3);
    chk("sub4_done_t", 1, done_t[1], 7);
    run_frame(2, 0, 0);
    chk_four("sub4_rl1_pix", 2, 0, 2, 8, 10);
    chk("sub4_rl1_first_wr_t", 2, wlog_t[2][0], 2);
    chk("sub4_rl1_done_t", 2, done_t[2], 6);
    run_frame(1, 1, 0);
    chk_four("avg4_pix", 1, 2, 4, 10, 12);
    begin
      int er [8];
      er = '{0, 1, 4, 5, 2, 3, 6, 7};
      for (int i = 0; i < 8; i++) chk("avg4_rd_seq", 1, rlog[1][i], er[i]);
    end
    chk("avg4_done_t", 1, done_t[1], 19);
    run_frame(1, 1, 1);
    chk_four("avg4_sat_pix", 1, 255, 255, 255, 255);
    run_frame(0, 0, 2);
    chk("big_sub_writes", 0, wcount[0], 1024);
    chk("big_sub_done_t", 0, done_t[0], 1027);
    chk("big_sub_first_pix", 0, wlog_v[0][0], 5);
    run_frame(0, 1, 2);
    chk("big_avg_writes", 0, wcount[0], 1024);
    chk("big_avg_done_t", 0, done_t[0], 4099);
    go(1, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    start[1] = 1'b1;
    mode[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    @(posedge clk);
    #1;
    start[1] = 1'b1;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    chk_four("ignored_start_pix", 1, 0, 2, 8, 10);
    run_frame(1, 0, 0);
    chk_four("restart_pix", 1, 0, 2, 8, 10);
    chk("restart_done_t", 1, done_t[1], 7);
    go(0, 0, 2);
    repeat (110) @(posedge clk);
    #1;
    chk("midrst_progress", 0, wcount[0] >= 100 ? 1 : 0, 1);
    rst[0] = 1'b1;
    run[0] = 1'b0;
    #1;
    chk_zero("midrst", 0);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    run_frame(0, 0, 2);
    chk("after_rst_writes", 0, wcount[0], 1024);
    chk("after_rst_first_pix", 0, wlog_v[0][0], 5);
    chk("after_rst_done_t", 0, done_t[0], 1027);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
